// File: rtl/hamming_pkg.sv
// Shared types and bit map for the SECDED Hamming(8,4) control path.
// Word order on the switches and datapath: {g0,w3,w2,w1,p2,w0,p1,p0}.
package hamming_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, CORRECT, DONE} estado_t;
  typedef enum logic [1:0] {SIN_ERROR, ERR_SIMPLE, ERR_DOBLE, ERR_TIMEOUT} clase_error_t;

  localparam int BIT_P0 = 0;
  localparam int BIT_P1 = 1;
  localparam int BIT_W0 = 2;
  localparam int BIT_P2 = 3;
  localparam int BIT_W1 = 4;
  localparam int BIT_W2 = 5;
  localparam int BIT_W3 = 6;
  localparam int BIT_G0 = 7;

  function automatic logic [3:0] extraer_dato(input logic [7:0] w);
    return {w[BIT_W0], w[BIT_W1], w[BIT_W2], w[BIT_W3]};
  endfunction

endpackage

// File: rtl/control_hamming_sincronizador.sv
// Button front end: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce is built only when CONTROL_HAMMING_DEBOUNCE_EN is defined.
module sincronizador_boton #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic cargar_pulso_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       nivel;

  // Chain resets to "pressed" so a button held across reset never fires a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], btn_i};
  end

`ifdef CONTROL_HAMMING_DEBOUNCE_EN
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [DBW-1:0] db_cnt_q;
  logic           estable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      estable_q <= 1'b1;
    end else if (sync_q[1] == estable_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
      estable_q <= sync_q[1];
      db_cnt_q  <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign nivel = estable_q;
`else
  assign nivel = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= nivel;
  end

  assign cargar_pulso_o = nivel & ~prev_q;

endmodule

// File: rtl/control_hamming.sv
// Sequencer for the Hamming(8,4) syndrome datapath: load, req/ack, classify, correct, hold.
// Optional button debounce via CONTROL_HAMMING_DEBOUNCE_EN.
module control_hamming
  import hamming_pkg::*;
#(
  parameter int TIMEOUT         = 16,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_cargar,
  input  logic [3:0]   conmutador_4,
  input  logic [7:0]   conmutador_8,
  output logic [7:0]   dp_palabra,
  output logic         dp_req,
  input  logic         dp_ack,
  input  logic [3:0]   dp_sindrome,
  output logic [7:0]   palabra_corregida,
  output logic [3:0]   dato_corregido,
  output clase_error_t clase_error,
  output logic [2:0]   posicion_error,
  output logic         coincide,
  output logic         resultado_valido,
  output logic         ocupado
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic         cargar_pulso;
  estado_t      estado_q;
  logic [3:0]   ref_q;
  logic [7:0]   rx_q;
  logic [3:0]   sind_q;
  logic [CW-1:0] cnt_q;
  logic         req_q, valid_q, ocup_q, coinc_q;
  logic [7:0]   corr_q;
  logic [3:0]   dato_q;
  logic [2:0]   pos_q;
  clase_error_t clase_q;

  logic [7:0]   corr_d;
  logic [3:0]   dato_d;
  logic [2:0]   pos_d;
  clase_error_t clase_d;
  logic         coinc_d;
  logic [2:0]   s;
  logic         g;

  sincronizador_boton #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sinc (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_i          (btn_cargar),
    .cargar_pulso_o (cargar_pulso)
  );

  // Syndrome position s maps to bit s-1; a lone g0 flag means the parity bit itself flipped.
  always_comb begin
    s       = sind_q[2:0];
    g       = sind_q[3];
    corr_d  = rx_q;
    pos_d   = 3'd0;
    clase_d = SIN_ERROR;
    if (g) begin
      clase_d = ERR_SIMPLE;
      if (s != 3'd0) begin
        corr_d = rx_q ^ (8'd1 << (s - 3'd1));
        pos_d  = s;
      end else begin
        corr_d = rx_q ^ (8'd1 << BIT_G0);
      end
    end else if (s != 3'd0) begin
      clase_d = ERR_DOBLE;
    end
    dato_d  = extraer_dato(corr_d);
    coinc_d = (clase_d != ERR_DOBLE) && (dato_d == ref_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= IDLE;
      ref_q    <= '0;
      rx_q     <= '0;
      sind_q   <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      ocup_q   <= 1'b0;
      corr_q   <= '0;
      dato_q   <= '0;
      pos_q    <= '0;
      clase_q  <= SIN_ERROR;
      coinc_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (estado_q)
        IDLE, DONE: begin
          if (cargar_pulso) begin
            ref_q    <= conmutador_4;
            rx_q     <= conmutador_8;
            cnt_q    <= '0;
            req_q    <= 1'b1;
            ocup_q   <= 1'b1;
            corr_q   <= '0;
            dato_q   <= '0;
            pos_q    <= '0;
            clase_q  <= SIN_ERROR;
            coinc_q  <= 1'b0;
            estado_q <= CHECK;
          end
        end
        CHECK: begin
          if (dp_ack && req_q) begin
            sind_q   <= dp_sindrome;
            req_q    <= 1'b0;
            estado_q <= CORRECT;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            req_q    <= 1'b0;
            ocup_q   <= 1'b0;
            valid_q  <= 1'b1;
            corr_q   <= rx_q;
            dato_q   <= extraer_dato(rx_q);
            pos_q    <= '0;
            clase_q  <= ERR_TIMEOUT;
            coinc_q  <= 1'b0;
            estado_q <= DONE;
          end else if (cnt_q != CW'(TIMEOUT)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CORRECT: begin
          ocup_q   <= 1'b0;
          valid_q  <= 1'b1;
          corr_q   <= corr_d;
          dato_q   <= dato_d;
          pos_q    <= pos_d;
          clase_q  <= clase_d;
          coinc_q  <= coinc_d;
          estado_q <= DONE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign dp_palabra        = rx_q;
  assign dp_req            = req_q;
  assign palabra_corregida = corr_q;
  assign dato_corregido    = dato_q;
  assign clase_error       = clase_q;
  assign posicion_error    = pos_q;
  assign coincide          = coinc_q;
  assign resultado_valido  = valid_q;
  assign ocupado           = ocup_q;

endmodule

// File: tb/tb_control_hamming.sv
// Self-checking bench for control_hamming: directed vectors, randomized SECDED errors,
// timeout, reset and button-handling scenarios against a behavioural Hamming model.
module tb_control_hamming;
  import hamming_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_cargar = 1'b0;
  logic [3:0]   conmutador_4 = '0;
  logic [7:0]   conmutador_8 = '0;
  logic [7:0]   dp_palabra;
  logic         dp_req;
  logic         dp_ack = 1'b0;
  logic [3:0]   dp_sindrome = '0;
  logic [7:0]   palabra_corregida;
  logic [3:0]   dato_corregido;
  clase_error_t clase_error;
  logic [2:0]   posicion_error;
  logic         coincide;
  logic         resultado_valido;
  logic         ocupado;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_neg = 0, valid_neg = 0, last_req_neg = 0;
  int n_valid = 0, n_loads = 0;
  int wait_cnt = 0, ack_delay = 0;
  bit ack_en = 1'b1, force_ack = 1'b0, req_prev = 1'b0;

  control_hamming #(.TIMEOUT(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_cargar(btn_cargar),
    .conmutador_4(conmutador_4), .conmutador_8(conmutador_8),
    .dp_palabra(dp_palabra), .dp_req(dp_req), .dp_ack(dp_ack), .dp_sindrome(dp_sindrome),
    .palabra_corregida(palabra_corregida), .dato_corregido(dato_corregido),
    .clase_error(clase_error), .posicion_error(posicion_error), .coincide(coincide),
    .resultado_valido(resultado_valido), .ocupado(ocupado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Syndrome = XOR of Hamming positions of set bits; g0 flag = odd overall parity.
  function automatic logic [3:0] syn_model(input logic [7:0] w);
    logic [2:0] sx;
    sx = 3'd0;
    for (int p = 1; p <= 7; p++) if (w[p-1]) sx = sx ^ 3'(p);
    return {^w, sx};
  endfunction

  // Data {w0,w1,w2,w3} -> codeword {g0,w3,w2,w1,p2,w0,p1,p0}, even overall parity.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic w0, w1, w2, w3;
    logic [6:0] c7;
    w0 = d[3]; w1 = d[2]; w2 = d[1]; w3 = d[0];
    c7 = {w3, w2, w1, w1 ^ w2 ^ w3, w0, w0 ^ w2 ^ w3, w0 ^ w1 ^ w3};
    return {^c7, c7};
  endfunction

  // Datapath model: acks after ack_delay CHECK cycles with the true syndrome.
  always @(negedge clk) begin
    if (!rst_n) begin
      dp_ack = 1'b0;
    end else if (force_ack) begin
      dp_ack = 1'b1;
      dp_sindrome = 4'b0101;
    end else if (dp_req && ack_en && wait_cnt >= ack_delay) begin
      dp_ack = 1'b1;
      dp_sindrome = syn_model(dp_palabra);
      ack_neg = cyc;
    end else begin
      dp_ack = 1'b0;
    end
    wait_cnt = dp_req ? wait_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (resultado_valido) begin
      n_valid++;
      valid_neg = cyc;
    end
    if (dp_req) last_req_neg = cyc;
    if (dp_req && !req_prev) n_loads++;
    req_prev = dp_req;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press();
    btn_cargar = 1'b1;
    tick(4);
    btn_cargar = 1'b0;
  endtask

  // Load one word and wait (bounded) for a result pulse.
  task automatic cargar(input logic [3:0] r, input logic [7:0] rx, input int dly, output bit ok);
    int v0;
    conmutador_4 = r;
    conmutador_8 = rx;
    ack_delay = dly;
    ack_en = 1'b1;
    v0 = n_valid;
    press();
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (n_valid != v0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    int v0;
    bit ok;
    rst_n = 1'b0;
    btn_cargar = 1'b1;
    tick(3);
    checks++;
    if ({dp_palabra, dp_req, palabra_corregida, dato_corregido, clase_error, posicion_error,
         coincide, resultado_valido, ocupado} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b pal=%h cls=%0d expected all zero", dp_req, palabra_corregida, clase_error);
    end
    rst_n = 1'b1;
    tick(10);
    checks++;
    if (n_loads !== 0 || dp_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_btn: got loads=%0d req=%b expected 0/0", n_loads, dp_req);
    end
    btn_cargar = 1'b0;
    tick(5);
    v0 = n_valid;
    cargar(4'b1011, 8'h66, 0, ok);
    tick(10);
    checks++;
    if (!ok || n_loads !== 1 || n_valid - v0 !== 1) begin
      errors++;
      $display("FAIL reset_one_load: got ok=%b loads=%0d pulses=%0d expected 1/1/1", ok, n_loads, n_valid - v0);
    end
  endtask

  task automatic test_directed();
    logic [7:0] rx_t [4] = '{8'h66, 8'h76, 8'hE6, 8'h65};
    clase_error_t cls_t [4] = '{SIN_ERROR, ERR_SIMPLE, ERR_SIMPLE, ERR_DOBLE};
    logic [7:0] pal_t [4] = '{8'h66, 8'h66, 8'h66, 8'h65};
    logic [2:0] pos_t [4] = '{3'd0, 3'd5, 3'd0, 3'd0};
    logic       co_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit ok;
    int v0;
    for (int k = 0; k < 4; k++) begin
      v0 = n_valid;
      cargar(4'b1011, rx_t[k], 0, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL dir%0d_timeout: no result pulse within bound", k);
        continue;
      end
      checks++;
      if (clase_error !== cls_t[k] || palabra_corregida !== pal_t[k] || posicion_error !== pos_t[k] ||
          dato_corregido !== 4'b1011 || coincide !== co_t[k]) begin
        errors++;
        $display("FAIL dir%0d_result: got cls=%0d pal=%h pos=%0d dato=%b co=%b expected cls=%0d pal=%h pos=%0d dato=1011 co=%b",
                 k, clase_error, palabra_corregida, posicion_error, dato_corregido, coincide,
                 cls_t[k], pal_t[k], pos_t[k], co_t[k]);
      end
      checks++;
      if (valid_neg - ack_neg !== 2) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d expected 2", k, valid_neg - ack_neg);
      end
      tick(8);
      checks++;
      if (n_valid - v0 !== 1 || clase_error !== cls_t[k] || palabra_corregida !== pal_t[k]) begin
        errors++;
        $display("FAIL dir%0d_hold: got pulses=%0d cls=%0d pal=%h expected 1 pulse, held result", k, n_valid - v0, clase_error, palabra_corregida);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] data, r, e_dato;
    logic [7:0] cw, rx, e_pal;
    logic [2:0] e_pos;
    clase_error_t e_cls;
    logic e_co;
    int nf, b1, b2, dly;
    bit ok;
    for (int it = 0; it < 24; it++) begin
      data = 4'($urandom);
      r = ($urandom_range(3) == 0) ? 4'($urandom) : data;
      cw = encode(data);
      nf = $urandom_range(2);
      b1 = $urandom_range(7);
      do b2 = $urandom_range(7); while (b2 == b1);
      dly = $urandom_range(5);
      rx = cw;
      if (nf >= 1) rx[b1] = ~rx[b1];
      if (nf == 2) rx[b2] = ~rx[b2];
      case (nf)
        0: begin e_cls = SIN_ERROR;  e_pal = cw; e_pos = 3'd0; end
        1: begin e_cls = ERR_SIMPLE; e_pal = cw; e_pos = (b1 == 7) ? 3'd0 : 3'(b1 + 1); end
        default: begin e_cls = ERR_DOBLE; e_pal = rx; e_pos = 3'd0; end
      endcase
      e_dato = (nf < 2) ? data : {rx[2], rx[4], rx[5], rx[6]};
      e_co = (nf < 2) && (data == r);
      cargar(r, rx, dly, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd%0d_timeout: no result pulse for rx=%h", it, rx);
        continue;
      end
      checks++;
      if (clase_error !== e_cls || palabra_corregida !== e_pal || posicion_error !== e_pos ||
          dato_corregido !== e_dato || coincide !== e_co) begin
        errors++;
        $display("FAIL rnd%0d: rx=%h got cls=%0d pal=%h pos=%0d dato=%b co=%b expected cls=%0d pal=%h pos=%0d dato=%b co=%b",
                 it, rx, clase_error, palabra_corregida, posicion_error, dato_corregido, coincide,
                 e_cls, e_pal, e_pos, e_dato, e_co);
      end
      checks++;
      if (valid_neg - ack_neg !== 2) begin
        errors++;
        $display("FAIL rnd%0d_latency: got %0d expected 2", it, valid_neg - ack_neg);
      end
      tick(3);
    end
  endtask

  task automatic test_timeout();
    int v0, reqc;
    bit got;
    ack_en = 1'b0;
    conmutador_4 = 4'b1011;
    conmutador_8 = 8'h66;
    v0 = n_valid;
    reqc = 0;
    got = 1'b0;
    btn_cargar = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 4) btn_cargar = 1'b0;
      tick();
      if (dp_req) reqc++;
      if (n_valid != v0) begin got = 1'b1; break; end
    end
    btn_cargar = 1'b0;
    checks++;
    if (!got || reqc !== 16) begin
      errors++;
      $display("FAIL timeout_cycles: got pulse=%b req_cycles=%0d expected 1/16", got, reqc);
    end
    checks++;
    if (clase_error !== ERR_TIMEOUT || dp_req !== 1'b0 || coincide !== 1'b0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: got cls=%0d req=%b co=%b busy=%b expected 3/0/0/0", clase_error, dp_req, coincide, ocupado);
    end
    checks++;
    if (valid_neg - last_req_neg !== 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected 1", valid_neg - last_req_neg);
    end
    force_ack = 1'b1;
    tick(4);
    force_ack = 1'b0;
    tick(4);
    checks++;
    if (n_valid - v0 !== 1 || clase_error !== ERR_TIMEOUT || dp_req !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: got pulses=%0d cls=%0d req=%b expected 1/3/0", n_valid - v0, clase_error, dp_req);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int v0, l0;
    ack_en = 1'b0;
    conmutador_8 = 8'h76;
    press();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dp_req) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL mid_enter_check: got req=%b busy=%b expected 1/1", dp_req, ocupado);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dp_palabra, dp_req, palabra_corregida, dato_corregido, clase_error, posicion_error,
         coincide, resultado_valido, ocupado} !== 29'd0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b pal=%h busy=%b expected all zero", dp_req, dp_palabra, ocupado);
    end
    tick(2);
    rst_n = 1'b1;
    ack_en = 1'b1;
    l0 = n_loads;
    tick(6);
    checks++;
    if (dp_req !== 1'b0 || n_loads !== l0) begin
      errors++;
      $display("FAIL mid_no_restart: got req=%b loads=%0d expected 0/%0d", dp_req, n_loads, l0);
    end
    // Second press lands while the first load is still waiting for ack.
    ack_delay = 12;
    conmutador_4 = 4'b1011;
    conmutador_8 = 8'h66;
    v0 = n_valid;
    l0 = n_loads;
    press();
    for (int i = 0; i < 20; i++) begin
      if (dp_req) break;
      tick();
    end
    btn_cargar = 1'b1;
    tick(3);
    btn_cargar = 1'b0;
    checks++;
    if (dp_req !== 1'b1) begin
      errors++;
      $display("FAIL busy_press_in_check: got req=%b expected 1", dp_req);
    end
    tick(40);
    checks++;
    if (n_valid - v0 !== 1 || n_loads - l0 !== 1 || dp_req !== 1'b0 || clase_error !== SIN_ERROR) begin
      errors++;
      $display("FAIL busy_press_ignored: got pulses=%0d loads=%0d req=%b cls=%0d expected 1/1/0/0",
               n_valid - v0, n_loads - l0, dp_req, clase_error);
    end
    ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
